// File: rtl/booth_seq_ctrl.sv
// Start/iteration sequencer for the SIMD radix-2 Booth multiplier accumulator.
// Optional feature: define BOOTH_ABORT_EN to add the abort input.
module booth_seq_ctrl #(
    parameter int CNT_W = 5,
    parameter int N16   = 16,
    parameter int N8    = 8,
    parameter int N4    = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       mode_in,
`ifdef BOOTH_ABORT_EN
    input  logic             abort,
`endif
    output logic [1:0]       mode,
    output logic             clr,
    output logic             ld,
    output logic [CNT_W-1:0] iter_cnt,
    output logic             busy,
    output logic             done,
    output logic             err
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_INIT,
        S_ITER,
        S_DONE
    } state_e;

    state_e           state_q, state_d;
    logic [1:0]       mode_q, mode_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] cnt_last;
    logic             err_q, err_d;
    logic             abort_w;

`ifdef BOOTH_ABORT_EN
    assign abort_w = abort;
`else
    assign abort_w = 1'b0;
`endif

    // Count value seen on the final ld cycle of the latched lane mode.
    always_comb begin
        case (mode_q)
            2'b00:   cnt_last = CNT_W'(N16 - 1);
            2'b01:   cnt_last = CNT_W'(N8 - 1);
            default: cnt_last = CNT_W'(N4 - 1);
        endcase
    end

    // NOTE: every variable gets a default before the case so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        cnt_d   = cnt_q;
        err_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (mode_in == 2'b11) begin
                        err_d = 1'b1;
                    end else begin
                        state_d = S_INIT;
                        mode_d  = mode_in;
                        cnt_d   = '0;
                    end
                end
            end
            S_INIT: begin
                state_d = abort_w ? S_IDLE : S_ITER;
            end
            S_ITER: begin
                // Abort wins over completion; the count freezes at its last value.
                if (abort_w) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == cnt_last) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all of them update together at the edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            mode_q  <= 2'b00;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    assign mode     = mode_q;
    assign iter_cnt = cnt_q;
    assign clr      = (state_q == S_INIT);
    assign ld       = (state_q == S_ITER);
    assign busy     = (state_q != S_IDLE);
    assign done     = (state_q == S_DONE);
    assign err      = err_q;

endmodule
